// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity-type codes and the
// three-sample majority vote used for bit recovery.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Bit-period edge counter with three centre samples and a majority vote.
// bit_end_o marks the last oversampling edge of the current bit.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      rx_i,
  input  logic                      active_i,
  input  logic                      start_i,
  input  logic [PRESCALE_WIDTH-1:0] prescale_i,
  output logic                      bit_value_o,
  output logic                      sample_done_o,
  output logic                      bit_end_o
);

  localparam logic [PRESCALE_WIDTH-1:0] ONE = PRESCALE_WIDTH'(1);

  logic [PRESCALE_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
  logic [PRESCALE_WIDTH-1:0] half;
  logic [2:0]                smp_q;
  logic                      done_q;

  assign half      = prescale_i >> 1;
  assign bit_end_o = active_i && (edge_cnt_q == (prescale_i - ONE));

  // The start-detection cycle is edge 0, so the counter enters START at 1.
  always_comb begin
    edge_cnt_d = '0;
    if (start_i) begin
      edge_cnt_d = ONE;
    end else if (active_i) begin
      edge_cnt_d = bit_end_o ? '0 : (edge_cnt_q + ONE);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      edge_cnt_q <= '0;
      smp_q      <= 3'b111;
      done_q     <= 1'b0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      if (active_i) begin
        if (edge_cnt_q == (half - ONE)) smp_q[0] <= rx_i;
        if (edge_cnt_q == half)         smp_q[1] <= rx_i;
        if (edge_cnt_q == (half + ONE)) begin
          smp_q[2] <= rx_i;
          done_q   <= 1'b1;
        end
        if (bit_end_o) done_q <= 1'b0;
      end else begin
        done_q <= 1'b0;
      end
    end
  end

  assign bit_value_o   = maj3(smp_q[0], smp_q[1], smp_q[2]);
  assign sample_done_o = done_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start/data/parity/stop FSM around the oversampling sampler,
// with parity and stop checks and registered result strobes.
module uart_rx
  import uart_pkg::*;
#(
  parameter int FRAME_WIDTH    = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  output logic [FRAME_WIDTH-1:0]    P_DATA,
  output logic                      data_valid,
  output logic                      par_err,
  output logic                      stp_err
);

  localparam int BW = $clog2(FRAME_WIDTH + 1);

  rx_state_e                 state_q, state_d;
  logic [PRESCALE_WIDTH-1:0] prescale_q;
  logic                      par_en_q, par_typ_q;
  logic [BW-1:0]             bit_cnt_q;
  logic [FRAME_WIDTH-1:0]    shift_q;
  logic                      par_bit_q;
  logic [FRAME_WIDTH-1:0]    p_data_q;
  logic                      dv_q, pe_q, se_q;

  logic start_det, active, bit_value, sample_done, bit_end, bit_done;
  logic last_data, frame_end, stop_bad, parity_bad, frame_ok;

  assign active    = (state_q != IDLE);
  assign start_det = (state_q == IDLE) && !RX_IN;
  assign bit_done  = bit_end && sample_done;
  assign last_data = (bit_cnt_q == BW'(FRAME_WIDTH - 1));

  uart_rx_sampler #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_sampler (
    .clk_i        (CLK),
    .rst_ni       (RST),
    .rx_i         (RX_IN),
    .active_i     (active),
    .start_i      (start_det),
    .prescale_i   (prescale_q),
    .bit_value_o  (bit_value),
    .sample_done_o(sample_done),
    .bit_end_o    (bit_end)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (!RX_IN) state_d = START;
      START:  if (bit_done) state_d = bit_value ? IDLE : DATA;
      DATA:   if (bit_done && last_data) state_d = par_en_q ? PARITY : STOP;
      PARITY: if (bit_done) state_d = STOP;
      STOP:   if (bit_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign frame_end  = (state_q == STOP) && bit_done;
  assign stop_bad   = !bit_value;
  assign parity_bad = par_en_q && (par_bit_q != ((^shift_q) ^ (par_typ_q == PAR_ODD)));
  assign frame_ok   = !stop_bad && !parity_bad;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      prescale_q <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= PAR_EVEN;
      bit_cnt_q  <= '0;
      p_data_q   <= '0;
      dv_q       <= 1'b0;
      pe_q       <= 1'b0;
      se_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      // Frame configuration is frozen at start detection.
      if (start_det) begin
        prescale_q <= Prescale;
        par_en_q   <= PAR_EN;
        par_typ_q  <= PAR_TYP;
      end
      if (state_q != DATA)  bit_cnt_q <= '0;
      else if (bit_done)    bit_cnt_q <= bit_cnt_q + BW'(1);
      dv_q <= frame_end && frame_ok;
      pe_q <= frame_end && parity_bad;
      se_q <= frame_end && stop_bad;
      if (frame_end && frame_ok) p_data_q <= shift_q;
    end
  end

  // LSB arrives first, so shifting in from the top leaves bit 0 in place.
  always_ff @(posedge CLK) begin
    if ((state_q == DATA) && bit_done)   shift_q   <= {bit_value, shift_q[FRAME_WIDTH-1:1]};
    if ((state_q == PARITY) && bit_done) par_bit_q <= bit_value;
  end

  assign P_DATA     = p_data_q;
  assign data_valid = dv_q;
  assign par_err    = pe_q;
  assign stp_err    = se_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are queued with their expected result
// and arrival cycle, then checked when a strobe appears.
module tb_uart_rx;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RX_IN = 1'b1;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [5:0] Prescale = 6'd16;
  logic [7:0] P_DATA;
  logic       data_valid, par_err, stp_err;

  uart_rx #(.FRAME_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .Prescale(Prescale), .P_DATA(P_DATA), .data_valid(data_valid),
    .par_err(par_err), .stp_err(stp_err)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc++;

  typedef struct {
    logic [7:0] d;
    logic       dv;
    logic       pe;
    logic       se;
    int         t;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] model_pdata = 8'h00;
  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (data_valid || par_err || stp_err) begin
      if (sb.size() == 0) begin
        chk("unexpected_strobe", {data_valid, par_err, stp_err}, 3'b000);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("data_valid", data_valid, e.dv);
        chk("par_err", par_err, e.pe);
        chk("stp_err", stp_err, e.se);
        chk("p_data", P_DATA, e.d);
        chk("strobe_cycle", cyc, e.t);
      end
    end
  end

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_bit(input logic b, input int p, input logic flip);
    for (int j = 0; j < p; j++) begin
      RX_IN = (flip && j == p / 2) ? ~b : b;
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input int p, input logic pe, input logic pt,
                            input logic bad_par, input logic stop, input int flip_idx);
    exp_t e;
    logic pbit, err;
    PAR_EN   = pe;
    PAR_TYP  = pt;
    Prescale = 6'(p);
    pbit = (^d) ^ pt ^ bad_par;
    err  = (pe & bad_par) | ~stop;
    if (!err) model_pdata = d;
    e.d  = model_pdata;
    e.dv = ~err;
    e.pe = pe & bad_par;
    e.se = ~stop;
    e.t  = cyc + (pe ? 11 : 10) * p;
    sb.push_back(e);
    send_bit(1'b0, p, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i], p, (i == flip_idx));
    if (pe) send_bit(pbit, p, 1'b0);
    send_bit(stop, p, 1'b0);
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_p_data", P_DATA, 8'h00);
    chk("rst_strobes", {data_valid, par_err, stp_err}, 3'b000);
    RST = 1'b1;
    idle(5);

    send_frame(8'hA5, 16, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    idle(4);
    send_frame(8'h3C, 8, 1'b1, 1'b0, 1'b0, 1'b1, -1);
    idle(4);
    send_frame(8'h3C, 8, 1'b1, 1'b0, 1'b1, 1'b1, -1);
    idle(4);
    // Back-to-back frames: no idle between stop and next start.
    send_frame(8'h00, 32, 1'b1, 1'b1, 1'b0, 1'b1, -1);
    send_frame(8'hFF, 32, 1'b1, 1'b1, 1'b0, 1'b1, -1);
    idle(4);
    send_frame(8'h55, 16, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    idle(20);

    Prescale = 6'd16;
    PAR_EN   = 1'b0;
    RX_IN    = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    idle(30);
    send_frame(8'h81, 16, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    idle(4);
    send_frame(8'h5A, 16, 1'b0, 1'b0, 1'b0, 1'b1, 3);
    idle(4);

    Prescale = 6'd16;
    PAR_EN   = 1'b0;
    send_bit(1'b0, 16, 1'b0);
    send_bit(1'b1, 16, 1'b0);
    send_bit(1'b0, 16, 1'b0);
    send_bit(1'b1, 7, 1'b0);
    RST = 1'b0;
    #1;
    chk("midrst_p_data", P_DATA, 8'h00);
    chk("midrst_strobes", {data_valid, par_err, stp_err}, 3'b000);
    model_pdata = 8'h00;
    RX_IN = 1'b1;
    repeat (3) @(posedge CLK);
    #3;
    RST = 1'b1;
    idle(4);
    send_frame(8'h7E, 16, 1'b0, 1'b0, 1'b0, 1'b1, -1);

    for (int k = 0; k < 2000 && sb.size() != 0; k++) @(posedge CLK);
    idle(20);
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver for the UART subsystem, pairing with the existing UART transmitter on the far end of the line. It oversamples RX_IN at a programmable prescale, majority-votes each bit, and deserializes LSB-first frames: start, FRAME_WIDTH data bits, optional even/odd parity, and one stop bit. It checks the parity and stop bits and presents each good word on P_DATA with a one-cycle data_valid strobe.

## Interface
- FRAME_WIDTH, 8: data bits per frame.
- PRESCALE_WIDTH, 6: width of the Prescale input and the edge counter.
- CLK  in  1  oversampling clock; the single clock of the block.
- RST  in  1  asynchronous active-low reset.
- RX_IN  in  1  serial line, idle high, already synchronous to CLK (synchronizer is upstream).
- PAR_EN  in  1  1 = parity bit present.
- PAR_TYP  in  1  0 = even, 1 = odd.
- Prescale  in  PRESCALE_WIDTH  CLK cycles per bit; supported values are 8, 16 and 32.
- P_DATA  out  FRAME_WIDTH  last good word; reset value 0.
- data_valid  out  1  one-cycle pulse when P_DATA is updated; reset value 0.
- par_err  out  1  one-cycle pulse on a frame with bad parity; reset value 0.
- stp_err  out  1  one-cycle pulse on a frame with stop bit = 0; reset value 0.

## Operation
- Start detection: in IDLE, RX_IN = 0 moves the FSM to START.
  - The edge counter loads 1, so the detection cycle counts as edge 0.
  - PAR_EN, PAR_TYP and Prescale are latched at this point and held for the whole frame. Changes mid-frame have no effect.
- Bit timing:
  - Each bit spans edge counts 0..P-1, where P is the latched Prescale.
  - Samples are taken at edge counts P/2-1, P/2 and P/2+1. The bit value is the majority of the three.
  - All state transitions happen at edge count P-1, and the edge counter then returns to 0.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - START: if the voted bit is 1, the start was a glitch. Return to IDLE with no outputs asserted. If 0, go to DATA.
  - DATA: shift the voted bit into bit position bit_cnt (LSB first). After FRAME_WIDTH bits, go to PARITY if PAR_EN = 1, else STOP.
  - PARITY: store the voted parity bit, then go to STOP.
  - STOP: go to IDLE. Frame checks are evaluated here.
- Frame checks at the last edge of STOP:
  - stp_err = (voted stop bit == 0).
  - par_err = PAR_EN and (received parity != XOR of the data bits XOR PAR_TYP).
  - If neither error is set: P_DATA is loaded and data_valid pulses.
  - If either error is set: no data_valid, and P_DATA keeps its previous value. Both errors may pulse in the same cycle.
- Back-to-back frames: IDLE is re-entered exactly when the next start bit may begin, so a start bit that immediately follows a stop bit is caught with no gap.
- Reset (RST low, at any time including mid-frame):
  - FSM goes to IDLE.
  - Counters and all outputs are cleared to 0.
  - Operation resumes on the first CLK edge after RST is released.

## Timing
- Let T be the first cycle RX_IN is low. For a frame with no parity, data_valid, par_err and stp_err are registered high in cycle T+(FRAME_WIDTH+2)·P. With parity, they are high in cycle T+(FRAME_WIDTH+3)·P.
- Each strobe is high for exactly 1 cycle.
- P_DATA changes in the same cycle as data_valid.
- The edge counter and bit counter must be wide enough for P = 32 and FRAME_WIDTH data bits without wrap-around.
- No outputs are combinational from RX_IN.

## Structure
- Shared package uart_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - constants PAR_EVEN = 0 and PAR_ODD = 1, shared with the transmitter.
- One sub-module, uart_rx_sampler, contains:
  - the edge counter;
  - the three-sample capture and majority vote;
  - outputs: bit_value, sample_done (bit value valid) and bit_end (edge count = P-1).
- The top level holds the FSM, bit counter, deserializer shift register, parity check and output registers.

## Test plan
- P=16, no parity, byte 0xA5 → data_valid at T+160, P_DATA=0xA5, par_err=0, stp_err=0.
- P=8, even parity, byte 0x3C with parity bit 0 → data_valid at T+88, P_DATA=0x3C. Same frame with parity bit 1 → par_err pulses, no data_valid, P_DATA unchanged.
- P=32, odd parity, 0x00 then 0xFF sent back-to-back with no idle gap → two data_valid pulses exactly 352 cycles apart, carrying 0x00 then 0xFF.
- Stop bit forced to 0 on byte 0x55 (P=16) → stp_err pulse at T+160, no data_valid.
- RX_IN low for 3 cycles then high (P=16) → FSM returns to IDLE, no strobes; a following valid frame 0x81 is received correctly. Separately, a single-cycle flip at edge count P/2 inside a data bit is outvoted and the word is correct.
- RST asserted mid-DATA → outputs 0 at once; after release, the next full frame 0x7E is received correctly with data_valid.
